fifo_ctrl: RTL and testbench

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_ctrl_if.sv | 29 ++
 rtl/fifo_ctrl.sv | 81 ++++++++
 tb/tb_fifo_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_if.sv
// Handshake and RAM-control bundle for fifo_ctrl.
// slave: the controller side; master: the producer/consumer/testbench side.
interface fifo_ctrl_if #(
    parameter int depth_log2_p = 2
);
    logic                    valid_i;
    logic                    ready_o;
    logic                    valid_o;
    logic                    ready_i;
    logic                    mem_we_o;
    logic [depth_log2_p-1:0] mem_waddr_o;
    logic [depth_log2_p-1:0] mem_raddr_o;
    logic [depth_log2_p:0]   count_o;
    logic                    full_o;
    logic                    empty_o;
    logic                    almost_full_o;

    modport slave (
        input  valid_i, ready_i,
        output ready_o, valid_o, mem_we_o, mem_waddr_o, mem_raddr_o,
               count_o, full_o, empty_o, almost_full_o
    );

    modport master (
        output valid_i, ready_i,
        input  ready_o, valid_o, mem_we_o, mem_waddr_o, mem_raddr_o,
               count_o, full_o, empty_o, almost_full_o
    );
endinterface

// File: rtl/fifo_ctrl.sv
// FIFO pointer/occupancy controller for an external 1r1w RAM with async read.
// Optional almost-full flag compiled in with macro FIFO_CTRL_ALMOST_FULL_EN;
// without it almost_full_o is tied low and the port list is unchanged.
module fifo_ctrl #(
    parameter int depth_log2_p         = 2,
    parameter int almost_full_margin_p = 1
) (
    input logic       clk_i,
    input logic       reset_i,
    fifo_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << depth_log2_p;
    localparam logic [depth_log2_p:0] FULL_CNT = (depth_log2_p + 1)'(DEPTH);

    // Reject illegal parameter combinations at elaboration.
    if (depth_log2_p < 1 || depth_log2_p > 8 ||
        almost_full_margin_p < 1 || almost_full_margin_p > DEPTH) begin : g_bad_cfg
        $error("fifo_ctrl: illegal depth_log2_p / almost_full_margin_p");
    end

    logic [depth_log2_p-1:0] wptr_q, wptr_d;
    logic [depth_log2_p-1:0] rptr_q, rptr_d;
    logic [depth_log2_p:0]   count_q, count_d;
    logic full, empty, ready, valid, wr_fire, rd_fire;

    // Flags come from the registered count only, so ready/valid have no
    // combinational path from the opposite side's handshake.
    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign ready   = ~full;
    assign valid   = ~empty;
    assign wr_fire = bus.valid_i & ready;
    assign rd_fire = valid & bus.ready_i;

    assign bus.ready_o     = ready;
    assign bus.valid_o     = valid;
    assign bus.full_o      = full;
    assign bus.empty_o     = empty;
    assign bus.count_o     = count_q;
    assign bus.mem_waddr_o = wptr_q;
    assign bus.mem_raddr_o = rptr_q;
    // A write in the reset cycle would land in RAM with state about to be
    // discarded, so the strobe is masked.
    assign bus.mem_we_o    = wr_fire & ~reset_i;

`ifdef FIFO_CTRL_ALMOST_FULL_EN
    localparam int AF_INT = DEPTH - almost_full_margin_p;
    localparam logic [depth_log2_p:0] AF_TH = (depth_log2_p + 1)'(AF_INT);
    assign bus.almost_full_o = (count_q >= AF_TH);
`else
    assign bus.almost_full_o = 1'b0;
`endif

    // Next-state: pointers wrap naturally at their width; count moves only
    // when exactly one side fires.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_fire) wptr_d = wptr_q + depth_log2_p'(1);
        if (rd_fire) rptr_d = rptr_q + depth_log2_p'(1);
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + (depth_log2_p + 1)'(1);
            2'b01:   count_d = count_q - (depth_log2_p + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset that overrides any handshake.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl at depth 4, margin 1.
// Inputs change 1 ns after the rising edge; outputs are checked 2 ns later.
module tb_fifo_ctrl;
`ifdef FIFO_CTRL_ALMOST_FULL_EN
    localparam logic AF_EN = 1'b1;
`else
    localparam logic AF_EN = 1'b0;
`endif

    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;
    int   n_chk   = 0;
    int   n_err   = 0;

    fifo_ctrl_if #(.depth_log2_p(2)) bus ();

    fifo_ctrl #(.depth_log2_p(2), .almost_full_margin_p(1)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic r);
        bus.valid_i = v;
        bus.ready_i = r;
        #2;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        drive(1'b1, 1'b1);
        chk("rst_we_masked", bus.mem_we_o, 0);
        step();
        step();
        reset_i = 1'b0;
        drive(1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

    initial begin
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        #1;
        do_reset();
        chk("rst_empty", bus.empty_o, 1);
        chk("rst_full", bus.full_o, 0);
        chk("rst_ready", bus.ready_o, 1);
        chk("rst_valid", bus.valid_o, 0);
        chk("rst_af", bus.almost_full_o, 0);
        chk("rst_waddr", bus.mem_waddr_o, 0);
        chk("rst_raddr", bus.mem_raddr_o, 0);
        chk("rst_count", bus.count_o, 0);

        // Fill: four accepted writes, fifth refused.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0);
            chk("fill_count", bus.count_o, i);
            chk("fill_af", bus.almost_full_o, (AF_EN && i >= 3) ? 1 : 0);
            if (i < 4) begin
                chk("fill_we", bus.mem_we_o, 1);
                chk("fill_waddr", bus.mem_waddr_o, i);
                chk("fill_ready", bus.ready_o, 1);
            end else begin
                chk("full_we", bus.mem_we_o, 0);
                chk("full_ready", bus.ready_o, 0);
                chk("full_flag", bus.full_o, 1);
            end
            step();
        end

        // Drain: four reads, then empty.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1);
            if (i < 4) begin
                chk("drain_valid", bus.valid_o, 1);
                chk("drain_raddr", bus.mem_raddr_o, i);
            end else begin
                chk("drain_empty", bus.empty_o, 1);
                chk("drain_valid0", bus.valid_o, 0);
                chk("drain_we0", bus.mem_we_o, 0);
            end
            step();
            chk("drain_count", bus.count_o, (i < 4) ? 3 - i : 0);
        end

        // Empty with both sides active: write only, no bypass.
        drive(1'b1, 1'b1);
        chk("emp_both_valid", bus.valid_o, 0);
        chk("emp_both_we", bus.mem_we_o, 1);
        chk("emp_both_waddr", bus.mem_waddr_o, 0);
        step();
        chk("emp_both_count", bus.count_o, 1);
        chk("emp_both_valid1", bus.valid_o, 1);

        // Bring occupancy to 2 (wptr 2, rptr 0), then six simultaneous transfers.
        drive(1'b1, 1'b0);
        step();
        chk("occ2_count", bus.count_o, 2);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1);
            chk("wrap_we", bus.mem_we_o, 1);
            chk("wrap_waddr", bus.mem_waddr_o, (2 + i) % 4);
            chk("wrap_raddr", bus.mem_raddr_o, i % 4);
            step();
            chk("wrap_count", bus.count_o, 2);
        end
        chk("wrap_wptr_end", bus.mem_waddr_o, 0);
        chk("wrap_rptr_end", bus.mem_raddr_o, 2);

        // Two more writes to full: waddr 0,1.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0);
            chk("refill_waddr", bus.mem_waddr_o, i);
            step();
        end
        chk("refill_full", bus.full_o, 1);
        chk("refill_count", bus.count_o, 4);

        // Full with both sides active: read only, no write-through.
        drive(1'b1, 1'b1);
        chk("full_both_ready", bus.ready_o, 0);
        chk("full_both_we", bus.mem_we_o, 0);
        chk("full_both_raddr", bus.mem_raddr_o, 2);
        step();
        drive(1'b0, 1'b0);
        chk("full_both_count", bus.count_o, 3);
        chk("full_both_full0", bus.full_o, 0);
        chk("full_both_raddr1", bus.mem_raddr_o, 3);
        chk("full_both_waddr", bus.mem_waddr_o, 2);
        chk("af_at3", bus.almost_full_o, AF_EN ? 1 : 0);

        // Reset mid-operation at count 3, pointers 3/0.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0);
            step();
        end
        drive(1'b0, 1'b0);
        chk("mid_count", bus.count_o, 3);
        chk("mid_waddr", bus.mem_waddr_o, 3);
        chk("mid_raddr", bus.mem_raddr_o, 0);
        chk("mid_af", bus.almost_full_o, AF_EN ? 1 : 0);
        reset_i = 1'b1;
        drive(1'b1, 1'b1);
        chk("mid_rst_we", bus.mem_we_o, 0);
        step();
        reset_i = 1'b0;
        drive(1'b0, 1'b0);
        chk("mid_rst_count", bus.count_o, 0);
        chk("mid_rst_waddr", bus.mem_waddr_o, 0);
        chk("mid_rst_raddr", bus.mem_raddr_o, 0);
        chk("mid_rst_empty", bus.empty_o, 1);
        chk("mid_rst_af", bus.almost_full_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
